// File: rtl/gcu_sb_pkg.sv
`default_nettype none
// ============================================================================
// gcu_sb_pkg : shared entry-state encoding and err_status bit indices
// Rev 1.0
// ============================================================================
package gcu_sb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_PEND   = 2'd2,
      ST_ISSUED = 2'd3
   } entry_state_e;

   localparam int unsigned c_err_w         = 3;
   localparam int unsigned c_err_underflow = 0;
   localparam int unsigned c_err_range     = 1;
   localparam int unsigned c_err_live_init = 2;

endpackage
`default_nettype wire

// File: rtl/gcu_sb_prio_enc.sv
`default_nettype none
// ============================================================================
// gcu_sb_prio_enc : lowest-index-first priority encoder over MAX_NODES requests
// Rev 1.0
// ============================================================================
module gcu_sb_prio_enc #(
   parameter int MAX_NODES = 8,
   parameter int IDX_W     = 4
) (
   input  logic [MAX_NODES-1:0] i_req,
   output logic                 o_valid,
   output logic [IDX_W-1:0]     o_idx
);

   // Scan from the top so the lowest set index is the last one written
   always_comb begin
      o_valid = 1'b0;
      o_idx   = '0;
      for (int i = MAX_NODES - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            o_valid = 1'b1;
            o_idx   = IDX_W'(i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/gcu_ready_scoreboard.sv
`default_nettype none
// ============================================================================
// gcu_ready_scoreboard : per-node child-completion scoreboard with ready offer
// Optional sticky error reporting under GCU_SB_ERR_STATUS_EN.   Rev 1.0
// ============================================================================
module gcu_ready_scoreboard
   import gcu_sb_pkg::*;
#(
   parameter int NODE_ID_W      = 4,
   parameter int MAX_NODES      = 8,
   parameter int CHILD_CNT_W    = 16,
   parameter int NUM_DONE_PORTS = 2
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                init_valid,
   input  logic [NODE_ID_W-1:0]                init_node_id,
   input  logic [CHILD_CNT_W-1:0]              init_children_count,
   input  logic [NUM_DONE_PORTS-1:0]           done_valid,
   input  logic [NUM_DONE_PORTS*NODE_ID_W-1:0] done_parent_id,
   input  logic                                release_valid,
   input  logic [NODE_ID_W-1:0]                release_node_id,
   output logic                                ready_valid,
   output logic [NODE_ID_W-1:0]                ready_node_id,
   input  logic                                ready_accept,
   input  logic                                query_valid,
   input  logic [NODE_ID_W-1:0]                query_node_id,
   output logic                                resp_valid,
   output logic [CHILD_CNT_W-1:0]              resp_pending_count,
   output logic                                resp_front_ready,
   output logic [2:0]                          err_status,
   input  logic                                err_clear
);

   localparam int HIT_W = $clog2(NUM_DONE_PORTS + 1);

   entry_state_e            state_q [MAX_NODES];
   entry_state_e            state_d [MAX_NODES];
   logic [CHILD_CNT_W-1:0]  count_q [MAX_NODES];
   logic [CHILD_CNT_W-1:0]  count_d [MAX_NODES];
   logic                    ready_valid_q, ready_valid_d;
   logic [NODE_ID_W-1:0]    ready_node_id_q, ready_node_id_d;
   logic                    resp_valid_q, resp_valid_d;
   logic                    resp_front_ready_q, resp_front_ready_d;
   logic [CHILD_CNT_W-1:0]  resp_pending_count_q, resp_pending_count_d;
   logic [c_err_w-1:0]      err_q, err_d, err_set;
   logic [MAX_NODES-1:0]    pend_stable;
   logic                    enc_valid;
   logic [NODE_ID_W-1:0]    enc_idx;
   logic                    accept_fire, offer_released, offer_still_pend;
   logic [HIT_W-1:0]        hits;

   function automatic logic in_range(input logic [NODE_ID_W-1:0] id);
      return 32'(id) < 32'(MAX_NODES);
   endfunction

   // Entry update: release > init > (done, accept)
   always_comb begin
      err_set     = '0;
      hits        = '0;
      accept_fire = ready_valid_q && ready_accept;
      if (init_valid && !in_range(init_node_id))       err_set[c_err_range] = 1'b1;
      if (release_valid && !in_range(release_node_id)) err_set[c_err_range] = 1'b1;
      if (query_valid && !in_range(query_node_id))     err_set[c_err_range] = 1'b1;
      for (int p = 0; p < NUM_DONE_PORTS; p++) begin
         if (done_valid[p] && !in_range(done_parent_id[p*NODE_ID_W +: NODE_ID_W]))
            err_set[c_err_range] = 1'b1;
      end
      for (int i = 0; i < MAX_NODES; i++) begin
         state_d[i] = state_q[i];
         count_d[i] = count_q[i];
         hits       = '0;
         for (int p = 0; p < NUM_DONE_PORTS; p++) begin
            if (done_valid[p] && done_parent_id[p*NODE_ID_W +: NODE_ID_W] == NODE_ID_W'(i))
               hits = hits + HIT_W'(1);
         end
         if (release_valid && release_node_id == NODE_ID_W'(i)) begin
            state_d[i] = ST_IDLE;
            count_d[i] = '0;
         end else if (init_valid && init_node_id == NODE_ID_W'(i)) begin
            count_d[i] = init_children_count;
            state_d[i] = (init_children_count != '0) ? ST_WAIT : ST_PEND;
            if (state_q[i] != ST_IDLE) err_set[c_err_live_init] = 1'b1;
         end else begin
            if (hits != '0) begin
               if (state_q[i] == ST_WAIT) begin
                  if (CHILD_CNT_W'(hits) >= count_q[i]) begin
                     if (CHILD_CNT_W'(hits) > count_q[i]) err_set[c_err_underflow] = 1'b1;
                     count_d[i] = '0;
                     state_d[i] = ST_PEND;
                  end else begin
                     count_d[i] = count_q[i] - CHILD_CNT_W'(hits);
                  end
               end else begin
                  err_set[c_err_underflow] = 1'b1;
               end
            end
            if (accept_fire && ready_node_id_q == NODE_ID_W'(i)) state_d[i] = ST_ISSUED;
         end
      end
   end

   // Only entries already PEND before this edge and still PEND after it are
   // eligible, which gives the one-cycle offer delay after entering PEND.
   always_comb begin
      offer_released   = release_valid && (release_node_id == ready_node_id_q);
      offer_still_pend = 1'b0;
      for (int i = 0; i < MAX_NODES; i++) begin
         pend_stable[i] = (state_q[i] == ST_PEND) && (state_d[i] == ST_PEND);
         if (ready_node_id_q == NODE_ID_W'(i) && state_d[i] == ST_PEND) offer_still_pend = 1'b1;
      end
      ready_valid_d   = ready_valid_q;
      ready_node_id_d = ready_node_id_q;
      if (ready_valid_q && offer_released) begin
         ready_valid_d = 1'b0;
      end else if (ready_valid_q && !ready_accept) begin
         ready_valid_d = offer_still_pend;
      end else begin
         ready_valid_d = enc_valid;
         if (enc_valid) ready_node_id_d = enc_idx;
      end
   end

   gcu_sb_prio_enc #(
      .MAX_NODES (MAX_NODES),
      .IDX_W     (NODE_ID_W)
   ) u_prio_enc (
      .i_req   (pend_stable),
      .o_valid (enc_valid),
      .o_idx   (enc_idx)
   );

   always_comb begin
      resp_valid_d         = query_valid;
      resp_pending_count_d = '0;
      resp_front_ready_d   = 1'b0;
      for (int i = 0; i < MAX_NODES; i++) begin
         if (query_valid && query_node_id == NODE_ID_W'(i)) begin
            resp_pending_count_d = count_d[i];
            resp_front_ready_d   = (state_d[i] != ST_IDLE) && (count_d[i] == '0);
         end
      end
   end

`ifdef GCU_SB_ERR_STATUS_EN
   always_comb begin
      err_d = (err_clear ? '0 : err_q) | err_set;
   end
`else
   logic err_unused;
   assign err_unused = ^{err_set, err_clear};
   always_comb begin
      err_d = '0;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MAX_NODES; i++) begin
            state_q[i] <= ST_IDLE;
            count_q[i] <= '0;
         end
         ready_valid_q        <= 1'b0;
         ready_node_id_q      <= '0;
         resp_valid_q         <= 1'b0;
         resp_pending_count_q <= '0;
         resp_front_ready_q   <= 1'b0;
         err_q                <= '0;
      end else begin
         for (int i = 0; i < MAX_NODES; i++) begin
            state_q[i] <= state_d[i];
            count_q[i] <= count_d[i];
         end
         ready_valid_q        <= ready_valid_d;
         ready_node_id_q      <= ready_node_id_d;
         resp_valid_q         <= resp_valid_d;
         resp_pending_count_q <= resp_pending_count_d;
         resp_front_ready_q   <= resp_front_ready_d;
         err_q                <= err_d;
      end
   end

   assign ready_valid        = ready_valid_q;
   assign ready_node_id      = ready_node_id_q;
   assign resp_valid         = resp_valid_q;
   assign resp_pending_count = resp_pending_count_q;
   assign resp_front_ready   = resp_front_ready_q;
   assign err_status         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_gcu_ready_scoreboard.sv
`default_nettype none
// ============================================================================
// tb_gcu_ready_scoreboard : directed scenarios plus random traffic vs a model
// Rev 1.0
// ============================================================================
module tb_gcu_ready_scoreboard;

   localparam int NODE_ID_W      = 4;
   localparam int MAX_NODES      = 8;
   localparam int CHILD_CNT_W    = 16;
   localparam int NUM_DONE_PORTS = 2;
`ifdef GCU_SB_ERR_STATUS_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif
   localparam int M_IDLE = 0, M_WAIT = 1, M_PEND = 2, M_ISSUED = 3;

   logic                                clk = 1'b0;
   logic                                rst_n;
   logic                                init_valid;
   logic [NODE_ID_W-1:0]                init_node_id;
   logic [CHILD_CNT_W-1:0]              init_children_count;
   logic [NUM_DONE_PORTS-1:0]           done_valid;
   logic [NUM_DONE_PORTS*NODE_ID_W-1:0] done_parent_id;
   logic                                release_valid;
   logic [NODE_ID_W-1:0]                release_node_id;
   logic                                ready_valid;
   logic [NODE_ID_W-1:0]                ready_node_id;
   logic                                ready_accept;
   logic                                query_valid;
   logic [NODE_ID_W-1:0]                query_node_id;
   logic                                resp_valid;
   logic [CHILD_CNT_W-1:0]              resp_pending_count;
   logic                                resp_front_ready;
   logic [2:0]                          err_status;
   logic                                err_clear;

   gcu_ready_scoreboard #(
      .NODE_ID_W      (NODE_ID_W),
      .MAX_NODES      (MAX_NODES),
      .CHILD_CNT_W    (CHILD_CNT_W),
      .NUM_DONE_PORTS (NUM_DONE_PORTS)
   ) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .init_valid          (init_valid),
      .init_node_id        (init_node_id),
      .init_children_count (init_children_count),
      .done_valid          (done_valid),
      .done_parent_id      (done_parent_id),
      .release_valid       (release_valid),
      .release_node_id     (release_node_id),
      .ready_valid         (ready_valid),
      .ready_node_id       (ready_node_id),
      .ready_accept        (ready_accept),
      .query_valid         (query_valid),
      .query_node_id       (query_node_id),
      .resp_valid          (resp_valid),
      .resp_pending_count  (resp_pending_count),
      .resp_front_ready    (resp_front_ready),
      .err_status          (err_status),
      .err_clear           (err_clear)
   );

   always #5 clk = ~clk;

   int         m_state [MAX_NODES];
   int         m_cnt   [MAX_NODES];
   bit         m_rv;
   int         m_rid;
   bit         m_resp_v;
   int         m_resp_cnt;
   bit         m_resp_fr;
   logic [2:0] m_err;
   int         n_checks = 0;
   int         n_fails  = 0;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < MAX_NODES; i++) begin
         m_state[i] = M_IDLE;
         m_cnt[i]   = 0;
      end
      m_rv = 0; m_rid = 0; m_resp_v = 0; m_resp_cnt = 0; m_resp_fr = 0; m_err = 3'b000;
   endtask

   task automatic idle_inputs();
      init_valid = 0; init_node_id = '0; init_children_count = '0;
      done_valid = '0; done_parent_id = '0;
      release_valid = 0; release_node_id = '0;
      ready_accept = 0; query_valid = 0; query_node_id = '0; err_clear = 0;
   endtask

   // Next-state of the reference model from the inputs present at this edge
   task automatic model_edge();
      int         ns   [MAX_NODES];
      int         nc   [MAX_NODES];
      int         hits [MAX_NODES];
      logic [2:0] es;
      bit         acc;
      int         sel;
      int         id;
      es  = 3'b000;
      acc = m_rv && ready_accept;
      sel = -1;
      for (int i = 0; i < MAX_NODES; i++) begin
         ns[i] = m_state[i]; nc[i] = m_cnt[i]; hits[i] = 0;
      end
      for (int p = 0; p < NUM_DONE_PORTS; p++) begin
         if (done_valid[p]) begin
            id = int'(done_parent_id[p*NODE_ID_W +: NODE_ID_W]);
            if (id >= MAX_NODES) es[1] = 1'b1;
            else hits[id]++;
         end
      end
      if (init_valid && init_node_id >= MAX_NODES)       es[1] = 1'b1;
      if (release_valid && release_node_id >= MAX_NODES) es[1] = 1'b1;
      if (query_valid && query_node_id >= MAX_NODES)     es[1] = 1'b1;
      for (int i = 0; i < MAX_NODES; i++) begin
         if (release_valid && release_node_id == i) begin
            ns[i] = M_IDLE; nc[i] = 0;
         end else if (init_valid && init_node_id == i) begin
            if (m_state[i] != M_IDLE) es[2] = 1'b1;
            nc[i] = int'(init_children_count);
            ns[i] = (nc[i] > 0) ? M_WAIT : M_PEND;
         end else begin
            if (hits[i] > 0) begin
               if (m_state[i] == M_WAIT) begin
                  if (hits[i] > m_cnt[i]) es[0] = 1'b1;
                  nc[i] = (hits[i] >= m_cnt[i]) ? 0 : m_cnt[i] - hits[i];
                  if (nc[i] == 0) ns[i] = M_PEND;
               end else begin
                  es[0] = 1'b1;
               end
            end
            if (acc && m_rid == i) ns[i] = M_ISSUED;
         end
      end
      for (int i = MAX_NODES - 1; i >= 0; i--) begin
         if (m_state[i] == M_PEND && ns[i] == M_PEND) sel = i;
      end
      if (m_rv && release_valid && release_node_id == m_rid) begin
         m_rv = 0;
      end else if (m_rv && !ready_accept) begin
         m_rv = (ns[m_rid] == M_PEND);
      end else begin
         m_rv = (sel >= 0);
         if (sel >= 0) m_rid = sel;
      end
      m_resp_v = query_valid; m_resp_cnt = 0; m_resp_fr = 0;
      if (query_valid && query_node_id < MAX_NODES) begin
         m_resp_cnt = nc[query_node_id];
         m_resp_fr  = (ns[query_node_id] != M_IDLE) && (nc[query_node_id] == 0);
      end
      m_err = ERR_EN ? ((err_clear ? 3'b000 : m_err) | es) : 3'b000;
      for (int i = 0; i < MAX_NODES; i++) begin
         m_state[i] = ns[i]; m_cnt[i] = nc[i];
      end
   endtask

   task automatic check_outputs();
      chk_eq("ready_valid", 32'(ready_valid), 32'(m_rv));
      if (m_rv) chk_eq("ready_node_id", 32'(ready_node_id), 32'(m_rid));
      chk_eq("resp_valid", 32'(resp_valid), 32'(m_resp_v));
      if (m_resp_v) begin
         chk_eq("resp_pending_count", 32'(resp_pending_count), 32'(m_resp_cnt));
         chk_eq("resp_front_ready", 32'(resp_front_ready), 32'(m_resp_fr));
      end
      chk_eq("err_status", 32'(err_status), 32'(m_err));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic check_all_zero(input string tag);
      chk_eq({tag, "_ready_valid"}, 32'(ready_valid), 32'd0);
      chk_eq({tag, "_ready_node_id"}, 32'(ready_node_id), 32'd0);
      chk_eq({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
      chk_eq({tag, "_resp_count"}, 32'(resp_pending_count), 32'd0);
      chk_eq({tag, "_err_status"}, 32'(err_status), 32'd0);
   endtask

   task automatic drive_random();
      idle_inputs();
      init_valid          = ($urandom_range(0, 3) == 0);
      init_node_id        = 4'($urandom_range(0, 9));
      init_children_count = 16'($urandom_range(0, 3));
      for (int p = 0; p < NUM_DONE_PORTS; p++) begin
         done_valid[p]                             = ($urandom_range(0, 2) == 0);
         done_parent_id[p*NODE_ID_W +: NODE_ID_W] = 4'($urandom_range(0, 9));
      end
      release_valid   = ($urandom_range(0, 5) == 0);
      release_node_id = 4'($urandom_range(0, 9));
      ready_accept    = 1'($urandom_range(0, 1));
      query_valid     = 1'($urandom_range(0, 1));
      query_node_id   = 4'($urandom_range(0, 9));
      err_clear       = ($urandom_range(0, 15) == 0);
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      model_reset();
      #3;
      check_all_zero("reset");
      #9 rst_n = 1'b1;

      // init with no children: immediately front-ready, offered one cycle later
      idle_inputs(); init_valid = 1; init_node_id = 1; init_children_count = 0;
      query_valid = 1; query_node_id = 1; tick();
      chk_eq("s1_resp_count", 32'(resp_pending_count), 32'd0);
      chk_eq("s1_front_ready", 32'(resp_front_ready), 32'd1);
      chk_eq("s1_no_offer_yet", 32'(ready_valid), 32'd0);
      idle_inputs(); tick();
      chk_eq("s1_offer_valid", 32'(ready_valid), 32'd1);
      chk_eq("s1_offer_id", 32'(ready_node_id), 32'd1);
      idle_inputs(); release_valid = 1; release_node_id = 1; tick();
      chk_eq("s6_release_drop", 32'(ready_valid), 32'd0);

      // both done ports hit the same parent in one cycle
      idle_inputs(); init_valid = 1; init_node_id = 2; init_children_count = 2; tick();
      idle_inputs(); done_valid = 2'b11; done_parent_id = {4'd2, 4'd2};
      query_valid = 1; query_node_id = 2; tick();
      chk_eq("s2_resp_count", 32'(resp_pending_count), 32'd0);
      chk_eq("s2_front_ready", 32'(resp_front_ready), 32'd1);
      idle_inputs(); tick();
      chk_eq("s2_offer_id", 32'(ready_node_id), 32'd2);
      idle_inputs(); release_valid = 1; release_node_id = 2; tick();

      // lowest index offered and held, next offered right after accept
      idle_inputs(); init_valid = 1; init_node_id = 5; init_children_count = 1; tick();
      idle_inputs(); init_valid = 1; init_node_id = 3; init_children_count = 0;
      done_valid = 2'b01; done_parent_id = {4'd0, 4'd5}; tick();
      idle_inputs(); tick();
      chk_eq("s3_offer_id", 32'(ready_node_id), 32'd3);
      idle_inputs(); tick(); tick();
      chk_eq("s3_hold_valid", 32'(ready_valid), 32'd1);
      chk_eq("s3_hold_id", 32'(ready_node_id), 32'd3);
      idle_inputs(); ready_accept = 1; tick();
      chk_eq("s3_next_valid", 32'(ready_valid), 32'd1);
      chk_eq("s3_next_id", 32'(ready_node_id), 32'd5);
      idle_inputs(); ready_accept = 1; tick();
      chk_eq("s3_drained", 32'(ready_valid), 32'd0);
      idle_inputs(); release_valid = 1; release_node_id = 3; tick();
      idle_inputs(); release_valid = 1; release_node_id = 5; tick();

      // over-decrement saturates and flags underflow
      idle_inputs(); init_valid = 1; init_node_id = 4; init_children_count = 1; tick();
      idle_inputs(); done_valid = 2'b11; done_parent_id = {4'd4, 4'd4};
      query_valid = 1; query_node_id = 4; tick();
      chk_eq("s4_sat_count", 32'(resp_pending_count), 32'd0);
      chk_eq("s4_err_underflow", 32'(err_status[0]), 32'(ERR_EN));
      idle_inputs(); err_clear = 1; tick();
      chk_eq("s4_err_cleared", 32'(err_status), 32'd0);
      idle_inputs(); release_valid = 1; release_node_id = 4; tick();

      // init wins over same-cycle done; out-of-range done only flags
      idle_inputs(); init_valid = 1; init_node_id = 6; init_children_count = 2;
      done_valid = 2'b01; done_parent_id = {4'd0, 4'd6}; tick();
      idle_inputs(); query_valid = 1; query_node_id = 6; tick();
      chk_eq("s5_init_priority", 32'(resp_pending_count), 32'd2);
      idle_inputs(); done_valid = 2'b01; done_parent_id = {4'd0, 4'd9};
      query_valid = 1; query_node_id = 6; tick();
      chk_eq("s5_err_range", 32'(err_status[1]), 32'(ERR_EN));
      chk_eq("s5_no_change", 32'(resp_pending_count), 32'd2);
      idle_inputs(); err_clear = 1; release_valid = 1; release_node_id = 6; tick();

      // random traffic with an asynchronous reset in the middle
      for (int n = 0; n < 3000; n++) begin
         drive_random();
         tick();
         if (n == 1500) begin
            rst_n = 1'b0;
            #1;
            check_all_zero("midrst");
            model_reset();
            #2 rst_n = 1'b1;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/gcu_ready_scoreboard.md
GCU_READY_SCOREBOARD -- requirements
Module: gcu_ready_scoreboard

Interface
REQ-001 SHALL have parameters: NODE_ID_W, default 4, node id width; MAX_NODES, default 8, entry count (≤ 2**NODE_ID_W); CHILD_CNT_W, default 16, child counter width; NUM_DONE_PORTS, default 2, parallel scatter-done ports.
REQ-002 SHALL have ports, in this order:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- init_valid  in  1  load one entry.
- init_node_id  in  NODE_ID_W  entry loaded by init.
- init_children_count  in  CHILD_CNT_W  outstanding children.
- done_valid  in  NUM_DONE_PORTS  per-port scatter-done strobe.
- done_parent_id  in  NUM_DONE_PORTS*NODE_ID_W  parent to decrement, per port.
- release_valid  in  1  free one entry.
- release_node_id  in  NODE_ID_W  entry freed by release.
- ready_valid  out  1  a ready node id is offered.
- ready_node_id  out  NODE_ID_W  offered id.
- ready_accept  in  1  consumer takes the offered id.
- query_valid  in  1  status read request.
- query_node_id  in  NODE_ID_W  entry to read.
- resp_valid  out  1  query response.
- resp_pending_count  out  CHILD_CNT_W  pending children of queried entry.
- resp_front_ready  out  1  queried entry is valid and its count is 0.
- err_status  out  3  sticky errors: [0] underflow, [1] id out of range, [2] init to a live entry.
- err_clear  in  1  clear err_status.

Function
REQ-003 SHALL keep per entry a count (CHILD_CNT_W) and a state: IDLE, WAIT, PEND, ISSUED.
REQ-004 SHALL on init: count←init_children_count; state←WAIT if count>0, else PEND; effective next edge.
REQ-005 SHALL on each edge decrement every entry in WAIT by the number of done ports naming it that cycle, 0..NUM_DONE_PORTS (duplicate ids accumulate).
REQ-006 SHALL move an entry from WAIT to PEND on the edge its count reaches 0.
REQ-007 SHALL saturate the count at 0 on over-decrement and set err_status[0].
REQ-008 SHALL set err_status[0] for a decrement to an IDLE, PEND or ISSUED entry, with no count change.
REQ-009 SHALL ignore any init, done, release or query id ≥ MAX_NODES and set err_status[1]; an ignored query still returns resp_valid with count 0 and front_ready 0.
REQ-010 SHALL give init priority over same-cycle decrements to the same entry; those decrements are dropped silently.
REQ-011 SHALL, on init to a non-IDLE entry, overwrite the entry and set err_status[2].
REQ-012 SHALL offer the lowest-index PEND entry as ready_valid/ready_node_id, registered, one cycle after that entry enters PEND.
REQ-013 SHALL hold ready_node_id stable while ready_valid=1 and ready_accept=0.
REQ-014 SHALL, on ready_valid & ready_accept, move the offered entry to ISSUED and offer the next PEND entry no earlier than the following cycle.
REQ-015 SHALL, on release, set the entry to IDLE and count to 0; if the entry is currently offered, drop ready_valid on the next edge.
REQ-016 SHALL give release priority over init, done and accept to the same entry in the same cycle.
REQ-017 SHALL answer a query with 1-cycle latency; resp_valid is a 1-cycle pulse; the response reflects state after the query-cycle edge updates.
REQ-018 SHALL set err_status bits on the edge after the error; when err_clear and a new error coincide, the new error wins.

Reset
REQ-019 SHALL on rst_n=0, asynchronously: all entries IDLE with count 0; ready_valid, resp_valid and err_status 0; ready_node_id and resp_pending_count 0.
REQ-020 SHALL discard all in-flight offers, queries and decrements on reset mid-operation; nothing is replayed after release.

Configuration
REQ-021 SHALL, with GCU_SB_ERR_STATUS_EN defined, implement err_status and err_clear as specified.
REQ-022 SHALL, without GCU_SB_ERR_STATUS_EN, tie err_status to 0 and ignore err_clear; functional behaviour is unchanged, including saturation and ignored out-of-range ids.

Structure
REQ-023 SHALL place the entry-state enum (IDLE/WAIT/PEND/ISSUED) and the err_status bit-index constants in package gcu_sb_pkg.
REQ-024 SHALL implement lowest-index PEND selection in sub-module gcu_sb_prio_enc, parametrised by MAX_NODES.

Verification
REQ-025 SHALL include these directed scenarios:
- init(1,0); query 1 -> resp count 0, front_ready 1; ready_valid with id 1 next cycle.
- init(2,2); both done ports name parent 2 in one cycle -> count 0, entry PEND; id 2 offered one cycle later.
- init(5,1) and init(3,0); hold ready_accept=0 -> id 3 offered and held; accept -> id 5 offered the cycle after.
- init(4,1); two decrements to 4 -> count 0, err_status[0]=1; err_clear -> 0.
- init(6,2) and a same-cycle done to 6 -> count 2; done to parent 9 -> err_status[1]=1, no state change.
- Entry offered, then release the same id -> ready_valid 0 next edge; assert rst_n mid-run -> all outputs 0 immediately.
